// File: rtl/floo_rob_slot_alloc.sv
`default_nettype none
// ============================================================================
// Module      : floo_rob_slot_alloc
// Description : Slot allocator and occupancy controller for a FlooNoC
//               chimney reorder buffer. Each request gets a contiguous block
//               of len+1 slots that wraps modulo the buffer size. Slots are
//               reclaimed in order as response beats drain, so a burst is
//               never accepted unless it can be stored.
// Ports       : clk_i / rst_i          clock, synchronous active-high reset
//               alloc_valid_i/_len_i   slot-block request and AXI len
//               alloc_ready_o/_idx_o   combinational grant and first slot
//               release_i/_last_i      one beat drained from the tail slot
//               free_o, txn_cnt_o      free slots, outstanding transactions
//               empty_o, full_o        occupancy decodes
//               err_o                  sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module floo_rob_slot_alloc #(
    parameter int  ReorderBufferSize = 64,
    parameter int  MaxTxns           = 8,
    parameter type ax_len_t          = logic [7:0],
    parameter type rob_idx_t         = logic [$clog2(ReorderBufferSize)-1:0]
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   alloc_valid_i,
    output logic                                   alloc_ready_o,
    input  ax_len_t                                alloc_len_i,
    output rob_idx_t                               alloc_idx_o,
    input  logic                                   release_i,
    input  logic                                   release_last_i,
    output logic [$clog2(ReorderBufferSize+1)-1:0] free_o,
    output logic [$clog2(MaxTxns+1)-1:0]           txn_cnt_o,
    output logic                                   empty_o,
    output logic                                   full_o,
    output logic                                   err_o
);

    localparam int C_IDX_W  = $bits(rob_idx_t);
    localparam int C_FREE_W = $clog2(ReorderBufferSize + 1);
    localparam int C_TXN_W  = $clog2(MaxTxns + 1);
    localparam int C_NEED_W = $bits(ax_len_t) + 1;
    // Common width wide enough for both the beat count and the free counter.
    localparam int C_CMP_W  = ((C_NEED_W > C_FREE_W) ? C_NEED_W : C_FREE_W) + 1;

    localparam logic [C_FREE_W-1:0] C_SIZE_F = C_FREE_W'(ReorderBufferSize);
    localparam logic [C_CMP_W-1:0]  C_SIZE_C = C_CMP_W'(ReorderBufferSize);
    localparam logic [C_TXN_W-1:0]  C_MAX_TX = C_TXN_W'(MaxTxns);

    rob_idx_t              r_head;
    rob_idx_t              r_tail;
    logic [C_FREE_W-1:0]   r_free;
    logic [C_TXN_W-1:0]    r_txn_cnt;
    logic                  r_err;

    logic [C_NEED_W-1:0]   w_need;
    logic [C_CMP_W-1:0]    w_need_c;
    logic                  w_grant;
    logic                  w_rel_ok;
    logic                  w_last_ok;
    logic                  w_err_now;
    logic [C_FREE_W-1:0]   w_free_nxt;
    logic [C_TXN_W-1:0]    w_txn_nxt;

    // Widened by one bit so that len = max yields the full beat count.
    assign w_need   = C_NEED_W'(alloc_len_i) + C_NEED_W'(1);
    assign w_need_c = C_CMP_W'(w_need);

    // Grant uses registered occupancy only; a same-cycle release does not help.
    assign w_grant = alloc_valid_i && !rst_i
                  && (w_need_c <= C_CMP_W'(r_free))
                  && (r_txn_cnt < C_MAX_TX);

    // A release into an empty buffer is dropped; a last-beat marker with no
    // outstanding transaction only loses its decrement.
    assign w_rel_ok  = release_i && (r_free != C_SIZE_F);
    assign w_last_ok = w_rel_ok && release_last_i && (r_txn_cnt != '0);

    assign w_err_now = (release_i && (r_free == C_SIZE_F))
                    || (release_i && release_last_i && (r_txn_cnt == '0))
                    || (alloc_valid_i && (w_need_c > C_SIZE_C));

    // A grant implies need <= free, and a valid release implies free < size,
    // so neither term can wrap the counter.
    assign w_free_nxt = r_free
                      - (w_grant  ? C_FREE_W'(w_need) : '0)
                      + (w_rel_ok ? C_FREE_W'(1)      : '0);

    assign w_txn_nxt  = r_txn_cnt
                      + (w_grant   ? C_TXN_W'(1) : '0)
                      - (w_last_ok ? C_TXN_W'(1) : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_free    <= C_SIZE_F;
            r_txn_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                // Truncation to the index width gives the modulo wrap.
                r_head <= r_head + C_IDX_W'(w_need);
            end
            if (w_rel_ok) begin
                r_tail <= r_tail + C_IDX_W'(1);
            end
            r_free    <= w_free_nxt;
            r_txn_cnt <= w_txn_nxt;
            r_err     <= r_err | w_err_now;
        end
    end

    assign alloc_ready_o = w_grant;
    assign alloc_idx_o   = r_head;
    assign free_o        = r_free;
    assign txn_cnt_o     = r_txn_cnt;
    assign empty_o       = (r_free == C_SIZE_F);
    assign full_o        = (r_free == '0);
    assign err_o         = r_err;

endmodule
`default_nettype wire
